// File: rtl/branch_predictor_btb_if.sv
// Fetch-lookup and execute-update bundle between the pipeline and the BTB.
// The pipeline is the master; the predictor is the slave.
interface branch_predictor_btb_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pcF;
    logic            pred_hitF;
    logic            pred_takenF;
    logic [XLEN-1:0] pred_pcF;
    logic            flush_all;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_is_jump;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_target;
    logic            upd_mispredict;
    logic [31:0]     hit_cnt;
    logic [31:0]     mispred_cnt;

    modport master (
        output pcF, flush_all, upd_valid, upd_pc, upd_is_jump, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        input  pred_hitF, pred_takenF, pred_pcF, upd_mispredict, hit_cnt, mispred_cnt
    );

    modport slave (
        input  pcF, flush_all, upd_valid, upd_pc, upd_is_jump, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        output pred_hitF, pred_takenF, pred_pcF, upd_mispredict, hit_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Zero-latency lookup in F; trained from resolved control transfers in E.
module branch_predictor_btb #(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    branch_predictor_btb_if.slave        bus
);
    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

    logic [ENTRIES-1:0]  valid_q;
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [TAGW-1:0]     tag_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];
    logic [31:0]         hit_cnt_q;
    logic [31:0]         mispred_cnt_q;

    logic [IDXW-1:0]     lidx, uidx;
    logic [TAGW-1:0]     ltag, utag;
    logic                lhit, uhit, mispredict;
    logic [CTR_BITS-1:0] ctr_upd;

    assign lidx = bus.pcF[IDXW+1:2];
    assign ltag = bus.pcF[XLEN-1:IDXW+2];
    assign uidx = bus.upd_pc[IDXW+1:2];
    assign utag = bus.upd_pc[XLEN-1:IDXW+2];

    // Lookup reads the array directly, so a same-cycle update is not visible yet.
    assign lhit = valid_q[lidx] && (tag_q[lidx] == ltag);
    assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

    assign bus.pred_hitF   = lhit;
    assign bus.pred_takenF = lhit && ctr_q[lidx][CTR_BITS-1];
    assign bus.pred_pcF    = bus.pred_takenF ? target_q[lidx] : bus.pcF + XLEN'(4);

    assign mispredict = bus.upd_valid &&
                        ((bus.upd_pred_taken != bus.upd_taken) ||
                         (bus.upd_taken && (bus.upd_pred_target != bus.upd_target)));
    assign bus.upd_mispredict = mispredict;
    assign bus.hit_cnt        = hit_cnt_q;
    assign bus.mispred_cnt    = mispred_cnt_q;

    // NOTE: ctr_upd gets a default before any branch so no latch is inferred.
    always_comb begin
        ctr_upd = ctr_q[uidx];
        if (bus.upd_is_jump) begin
            ctr_upd = CTR_MAX;
        end else if (bus.upd_taken) begin
            if (ctr_q[uidx] != CTR_MAX) ctr_upd = ctr_q[uidx] + CTR_BITS'(1);
        end else if (ctr_q[uidx] != '0) begin
            ctr_upd = ctr_q[uidx] - CTR_BITS'(1);
        end
    end

    // NOTE: state uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q       <= '0;
            hit_cnt_q     <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
        end else begin
            hit_cnt_q     <= hit_cnt_q + 32'(lhit);
            mispred_cnt_q <= mispred_cnt_q + 32'(mispredict);
            if (bus.flush_all) begin
                valid_q <= '0;
            end else if (bus.upd_valid) begin
                if (uhit) begin
                    ctr_q[uidx] <= ctr_upd;
                end else if (bus.upd_taken || bus.upd_is_jump) begin
                    valid_q[uidx] <= 1'b1;
                    ctr_q[uidx]   <= bus.upd_is_jump ? CTR_MAX : CTR_WEAK;
                end
            end
        end
    end

    // NOTE: tag/target storage has no reset; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (!bus.flush_all && bus.upd_valid && (bus.upd_taken || bus.upd_is_jump)) begin
            tag_q[uidx]    <= utag;
            target_q[uidx] <= bus.upd_target;
        end
    end
endmodule
